stream_elastic_fifo: RTL and testbench

STREAM_ELASTIC_FIFO -- requirements
Module: stream_elastic_fifo

---
 rtl/stream_elastic_fifo.sv | 129 ++++++++++++
 tb/tb_stream_elastic_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_elastic_fifo.sv
// stream_elastic_fifo
//   Elastic valid/ack FIFO between an upstream interface and a kernel input
//   port. The output is first-word fall-through with a registered dout. The
//   handshake flags are decoded from the stored count only, so there is no
//   combinational path from either side's handshake inputs.
//   An upstream stall watchdog raises a sticky overflow flag.
//
// Ports
//   clk      : single clock, rising edge
//   reset    : asynchronous active-low reset
//   flush    : synchronous clear of contents, pointers, watchdog and overflow
//   din      : upstream data
//   vld_in   : upstream data valid
//   ack_out  : acceptance to upstream, high while count < DEPTH
//   dout     : oldest stored word, held while vld_out=1 and ack_in=0
//   vld_out  : data valid to kernel, high while count > 0
//   ack_in   : kernel acceptance
//   count    : number of stored words, 0..DEPTH
//   overflow : sticky; set after 256 consecutive stalled upstream cycles

module stream_elastic_fifo #(
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [PAYLOAD_BITS-1:0] din,
    input  logic                    vld_in,
    output logic                    ack_out,
    output logic [PAYLOAD_BITS-1:0] dout,
    output logic                    vld_out,
    input  logic                    ack_in,
    output logic [DEPTH_BITS:0]     count,
    output logic                    overflow
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] ONE_CNT   = (DEPTH_BITS+1)'(1);

    logic [PAYLOAD_BITS-1:0] mem [DEPTH];
    logic [DEPTH_BITS-1:0]   wr_ptr;
    logic [DEPTH_BITS-1:0]   rd_ptr;
    logic [DEPTH_BITS-1:0]   rd_next;
    logic [7:0]              stall_cnt;
    logic                    push;
    logic                    pop;
    logic                    stall;

    assign ack_out = (count < DEPTH_CNT);
    assign vld_out = (count != '0);
    assign push    = vld_in & ack_out;
    assign pop     = vld_out & ack_in;
    assign stall   = vld_in & ~ack_out;
    assign rd_next = rd_ptr + 1'b1;

    // Storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Registered head-of-queue word. A push into an empty FIFO loads din
    // directly; a pop loads the next stored word, or din when the popped word
    // was the last one and a push replaces it on the same edge. A flush keeps
    // the last value, since dout is don't-care while vld_out=0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout <= '0;
        end else if (!flush) begin
            if (push && count == '0) begin
                dout <= din;
            end else if (pop) begin
                if (count > ONE_CNT) begin
                    dout <= mem[rd_next];
                end else if (push) begin
                    dout <= din;
                end
            end
        end
    end

    // The counter saturates at 255, and the 256th consecutive stalled edge
    // sets overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            overflow  <= 1'b0;
        end else if (flush) begin
            stall_cnt <= '0;
            overflow  <= 1'b0;
        end else if (stall) begin
            if (stall_cnt == 8'd255) begin
                overflow <= 1'b1;
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end else begin
            stall_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_stream_elastic_fifo.sv
// Directed bench for stream_elastic_fifo (PAYLOAD_BITS=32, DEPTH=16).
// Inputs change 1 time unit after each rising edge, and outputs are checked
// at that same point.

module tb_stream_elastic_fifo;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] din;
    logic        vld_in;
    logic        ack_out;
    logic [31:0] dout;
    logic        vld_out;
    logic        ack_in;
    logic [4:0]  count;
    logic        overflow;

    int tests;
    int fails;

    stream_elastic_fifo #(.PAYLOAD_BITS(32), .DEPTH_BITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .din      (din),
        .vld_in   (vld_in),
        .ack_out  (ack_out),
        .dout     (dout),
        .vld_out  (vld_out),
        .ack_in   (ack_in),
        .count    (count),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        reset  = 1'b0;
        flush  = 1'b0;
        din    = '0;
        vld_in = 1'b0;
        ack_in = 1'b0;

        // Reset state
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_vld_out", 32'(vld_out), 32'd0);
        check("rst_ack_out", 32'(ack_out), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_dout", dout, 32'd0);
        tick();
        reset = 1'b1;

        // Write/read: three pushes with ack_in low, then drain
        din = 32'h11; vld_in = 1'b1;
        check("wr_vld_before_push", 32'(vld_out), 32'd0);
        tick();
        check("wr_vld_after_push", 32'(vld_out), 32'd1);
        check("wr_dout0", dout, 32'h11);
        check("wr_count1", 32'(count), 32'd1);
        din = 32'h22; tick();
        check("wr_dout_hold", dout, 32'h11);
        din = 32'h33; tick();
        check("wr_count3", 32'(count), 32'd3);
        vld_in = 1'b0; ack_in = 1'b1;
        check("rd_dout_11", dout, 32'h11);
        tick();
        check("rd_dout_22", dout, 32'h22);
        check("rd_count2", 32'(count), 32'd2);
        tick();
        check("rd_dout_33", dout, 32'h33);
        check("rd_count1", 32'(count), 32'd1);
        tick();
        check("rd_count0", 32'(count), 32'd0);
        check("rd_vld_low", 32'(vld_out), 32'd0);
        check("rd_dout_keep", dout, 32'h33);
        ack_in = 1'b0;

        // Full: 16 accepted, 17th held until a pop frees space
        vld_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = 32'h100 + 32'(i);
            check("full_ack_before", 32'(ack_out), 32'd1);
            tick();
        end
        check("full_count16", 32'(count), 32'd16);
        check("full_ack_low", 32'(ack_out), 32'd0);
        din = 32'h110;
        tick();
        check("full_held_count", 32'(count), 32'd16);
        check("full_ack_still_low", 32'(ack_out), 32'd0);
        ack_in = 1'b1;
        tick();
        check("full_pop_count15", 32'(count), 32'd15);
        check("full_ack_back", 32'(ack_out), 32'd1);
        ack_in = 1'b0;
        tick();
        check("full_17th_in", 32'(count), 32'd16);
        vld_in = 1'b0; ack_in = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check("full_drain_order", dout, 32'h100 + 32'(i));
            tick();
        end
        check("full_drain_17th", dout, 32'h110);
        tick();
        check("full_drain_empty", 32'(count), 32'd0);
        ack_in = 1'b0;

        // Simultaneous push/pop at count=5 across pointer wrap
        vld_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 32'h200 + 32'(i);
            tick();
        end
        check("sim_count5", 32'(count), 32'd5);
        ack_in = 1'b1;
        for (int k = 0; k < 40; k++) begin
            din = 32'h205 + 32'(k);
            check("sim_order", dout, 32'h200 + 32'(k));
            tick();
            check("sim_count_stays", 32'(count), 32'd5);
        end
        vld_in = 1'b0;
        for (int j = 0; j < 5; j++) begin
            check("sim_tail_order", dout, 32'h228 + 32'(j));
            tick();
        end
        check("sim_empty", 32'(count), 32'd0);
        ack_in = 1'b0;

        // Watchdog: fill, then 256 stalled cycles
        vld_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = 32'h400 + 32'(i);
            tick();
        end
        check("wd_full", 32'(count), 32'd16);
        for (int i = 0; i < 255; i++) tick();
        check("wd_not_yet", 32'(overflow), 32'd0);
        tick();
        check("wd_set_256", 32'(overflow), 32'd1);
        vld_in = 1'b0; ack_in = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        check("wd_drained", 32'(count), 32'd0);
        check("wd_sticky", 32'(overflow), 32'd1);
        ack_in = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("wd_flush_clears", 32'(overflow), 32'd0);

        // Reset mid-stream with count=9
        vld_in = 1'b1;
        for (int i = 0; i < 9; i++) begin
            din = 32'h500 + 32'(i);
            tick();
        end
        vld_in = 1'b0;
        check("mrst_count9", 32'(count), 32'd9);
        #2;
        reset = 1'b0;
        #1;
        check("mrst_vld_out", 32'(vld_out), 32'd0);
        check("mrst_count", 32'(count), 32'd0);
        check("mrst_ack_out", 32'(ack_out), 32'd1);
        tick();
        reset = 1'b1;
        din = 32'hA5; vld_in = 1'b1;
        tick();
        vld_in = 1'b0;
        check("mrst_first_dout", dout, 32'hA5);
        check("mrst_count1", 32'(count), 32'd1);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        check("mrst_drained", 32'(count), 32'd0);

        // Flush with a simultaneous push
        vld_in = 1'b1;
        din = 32'h301; tick();
        din = 32'h302; tick();
        check("fl_count2", 32'(count), 32'd2);
        flush = 1'b1; ack_in = 1'b1; din = 32'h3FF;
        tick();
        flush = 1'b0; ack_in = 1'b0; vld_in = 1'b0;
        check("fl_count0", 32'(count), 32'd0);
        check("fl_vld_low", 32'(vld_out), 32'd0);
        check("fl_ack_high", 32'(ack_out), 32'd1);
        tick();
        check("fl_stays_empty", 32'(count), 32'd0);
        din = 32'h355; vld_in = 1'b1;
        tick();
        vld_in = 1'b0;
        check("fl_next_word", dout, 32'h355);
        check("fl_next_count", 32'(count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
